dot_accum: RTL and testbench
============================

DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits.
REQ-002 The block SHALL have parameter G, default 4, giving the accumulator guard bits; ACC_W = 2N+G.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the element-count width.
REQ-004 The block SHALL have parameter TMO, default N+4, giving the multiply timeout in cycles.
REQ-005 clk  in  1  the single clock; every register SHALL update on its rising edge.
REQ-006 rst_n  in  1  reset; it SHALL be synchronous and active-low.
REQ-007 in_valid / in_ready  in / out  1 / 1  element handshake.
REQ-008 in_a, in_b  in  N each  unsigned operands; in_last  in  1  marks the final element of the vector.
REQ-009 mul_load  out  1  one-cycle start pulse to the shift-add multiplier.
REQ-010 mul_a, mul_b  out  N each  operands to the multiplier.
REQ-011 mul_valid  in  1  multiplier idle/done level; mul_p  in  2N  product; mul_cout  in  1  product carry.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 out_sum  out  ACC_W  dot product; out_count  out  CNT_W  elements summed.
REQ-014 ovf  out  1  sticky overflow; err  out  1  sticky timeout.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and OUT.
REQ-016 In IDLE, in_ready SHALL be 1; in_valid&in_ready SHALL latch in_a, in_b and in_last, then move to ISSUE.
REQ-017 ISSUE SHALL assert mul_load for exactly one cycle with mul_a/mul_b driven from the latched operands, then move to WAIT.
REQ-018 mul_a/mul_b SHALL stay stable from ISSUE until WAIT exits.
REQ-019 WAIT SHALL ignore mul_valid on its first cycle; on a later cycle with mul_valid=1 it SHALL add mul_p, zero-extended to ACC_W, into acc and increment count.
REQ-020 After that accumulate edge, WAIT SHALL go to OUT if the latched last=1, else to IDLE.
REQ-021 Back-to-back throughput SHALL be one element per N+3 cycles with an N-cycle multiplier; in_ready SHALL be 0 outside IDLE.
REQ-022 If mul_cout=1 when accumulating, or the ACC_W sum carries out, ovf SHALL set.
REQ-023 If WAIT lasts TMO cycles without mul_valid, err SHALL set, acc and count SHALL clear, and the FSM SHALL return to IDLE.
REQ-024 In OUT, out_valid SHALL be 1 with out_sum=acc and out_count=count held stable.
REQ-025 out_valid&out_ready in OUT SHALL clear acc and count and return to IDLE; ovf and err SHALL clear on the same edge.
REQ-026 Count SHALL wrap modulo 2^CNT_W.
REQ-027 A vector that is only a single element with in_last=1 SHALL be legal.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, acc=0, count=0, mul_load=0, out_valid=0, ovf=0 and err=0.
REQ-029 mul_a and mul_b SHALL be 0 in reset; in_ready SHALL be 1 in the first cycle after reset release.
REQ-030 A reset in any state SHALL abandon the operation; a mul_valid arriving afterwards SHALL have no effect.

Configuration
REQ-031 With DOT_ACCUM_SAT_EN defined, an accumulation overflow SHALL clamp acc to all-ones (2^ACC_W-1) and hold it there until cleared.
REQ-032 Without DOT_ACCUM_SAT_EN, acc SHALL wrap modulo 2^ACC_W; ovf behaviour SHALL be identical in both builds.

Structure
REQ-033 A package dot_accum_pkg SHALL hold the state enum type and the default constants for N, G and TMO.
REQ-034 The saturating/wrapping adder SHALL be a sub-module dot_accum_add (ACC_W-bit add, carry out, macro-controlled clamp).
REQ-035 The multiplier SHALL be external, connected through the mul_* ports.

Verification (N=4 and a real N-cycle shift-add multiplier unless stated)
REQ-036 Single element (3,5,last) -> one out_valid with out_sum=15, out_count=1, ovf=0.
REQ-037 Elements (15,15),(15,15),(1,1,last) -> out_sum=451, out_count=3.
REQ-038 out_ready held low 5 cycles in OUT -> out_valid, out_sum and out_count stable; in_ready=0 throughout.
REQ-039 G=1, three elements (15,15) -> ovf=1, out_sum=511 with DOT_ACCUM_SAT_EN, out_sum=163 without.
REQ-040 rst_n low during WAIT, then a late mul_valid pulse -> FSM stays IDLE, acc=0, no out_valid.
REQ-041 Multiplier stub holding mul_valid=0 -> err=1 after 8 WAIT cycles, FSM returns to IDLE, in_ready=1.

Source files
------------

// File: rtl/dot_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dot_accum_pkg
//  Purpose  : Shared types and default constants for the dot-product
//             accumulator (state encoding, default N / G / CNT_W / TMO).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dot_accum_pkg;

  localparam int DEF_N       = 4;   // operand width
  localparam int DEF_G       = 4;   // accumulator guard bits
  localparam int DEF_CNT_W   = 8;   // element-count width
  localparam int TMO_MARGIN  = 4;   // multiply timeout slack beyond N cycles
  localparam int DEF_TMO     = DEF_N + TMO_MARGIN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dot_accum_add.sv
`default_nettype none
// ============================================================================
//  Module   : dot_accum_add
//  Purpose  : W-bit accumulator adder with carry detection. When the build
//             macro DOT_ACCUM_SAT_EN is defined, any overflow clamps the sum
//             to all-ones; otherwise the sum wraps modulo 2^W.
//  Ports    : a_i       in  W  current accumulator
//             b_i       in  W  addend (zero-extended product)
//             ext_ovf_i in  1  overflow already present in the addend
//             sum_o     out W  new accumulator value
//             ovf_o     out 1  carry out of the add OR ext_ovf_i
//  Revision : 1.0 - initial release
// ============================================================================
module dot_accum_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ext_ovf_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o    = full_sum[W] | ext_ovf_i;

`ifdef DOT_ACCUM_SAT_EN
  // Once clamped, every later non-zero add carries again, so the
  // accumulator stays pinned at all-ones until it is cleared.
  assign sum_o = ovf_o ? {W{1'b1}} : full_sum[W-1:0];
`else
  assign sum_o = full_sum[W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/dot_accum.sv
`default_nettype none
// ============================================================================
//  Module   : dot_accum
//  Purpose  : Streams (a,b) element pairs to an external shift-add
//             multiplier and accumulates the products into a dot product.
//             Build macro DOT_ACCUM_SAT_EN selects a saturating accumulator
//             (default: wrapping).
//  Ports    : clk, rst_n                 clock, synchronous active-low reset
//             in_valid/in_ready          element handshake
//             in_a, in_b, in_last        operands and end-of-vector flag
//             mul_load, mul_a, mul_b     multiplier start pulse and operands
//             mul_valid, mul_p, mul_cout multiplier done level and product
//             out_valid/out_ready        result handshake
//             out_sum, out_count         dot product and element count
//             ovf, err                   sticky overflow / timeout flags
//  Revision : 1.0 - initial release
// ============================================================================
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int G     = DEF_G,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TMO   = N + TMO_MARGIN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_a,
  input  logic [N-1:0]       in_b,
  input  logic               in_last,
  output logic               mul_load,
  output logic [N-1:0]       mul_a,
  output logic [N-1:0]       mul_b,
  input  logic               mul_valid,
  input  logic [2*N-1:0]     mul_p,
  input  logic               mul_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N+G-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               ovf,
  output logic               err
);

  localparam int ACC_W = 2 * N + G;
  localparam int WC_W  = $clog2(TMO + 1);

  state_t             state_q, state_d;
  logic [N-1:0]       a_q, a_d, b_q, b_d;
  logic               last_q, last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d, err_q, err_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;

  assign prod_ext = ACC_W'(mul_p);

  dot_accum_add #(.W(ACC_W)) u_add (
    .a_i       (acc_q),
    .b_i       (prod_ext),
    .ext_ovf_i (mul_cout),
    .sum_o     (add_sum),
    .ovf_o     (add_ovf)
  );

  // Operands come straight from the latch registers, which only change in
  // IDLE, so they are stable for the whole ISSUE/WAIT window.
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    last_d    = last_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    wcnt_d    = wcnt_q;
    in_ready  = 1'b0;
    mul_load  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          last_d  = in_last;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        mul_load = 1'b1;
        wcnt_d   = '0;
        state_d  = WAIT;
      end

      WAIT: begin
        wcnt_d = wcnt_q + WC_W'(1);
        // mul_valid still shows the previous "idle" level on the first
        // WAIT cycle, so it is only trusted from the second cycle on.
        if (mul_valid && (wcnt_q != '0)) begin
          acc_d   = add_sum;
          cnt_d   = cnt_q + CNT_W'(1);
          if (add_ovf) begin
            ovf_d = 1'b1;
          end
          state_d = last_q ? OUT : IDLE;
        end else if (wcnt_q == WC_W'(TMO - 1)) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dot_accum
//  Purpose  : Directed self-checking bench for dot_accum. Two instances share
//             one stimulus stream and one shift-add multiplier model:
//             dut0 uses default parameters, dut1 uses G=1 (9-bit accumulator).
//             Expected saturating/wrapping results follow DOT_ACCUM_SAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dot_accum;

  localparam int N   = 4;
  localparam int TMO = N + 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_a, in_b;
  logic        in_last;
  logic        out_ready;
  logic        mul_valid;
  logic [7:0]  mul_p;
  logic        mul_cout;

  logic        in_ready0, in_ready1;
  logic        mul_load0, mul_load1;
  logic [3:0]  mul_a0, mul_b0, mul_a1, mul_b1;
  logic        out_valid0, out_valid1;
  logic [11:0] out_sum0;
  logic [8:0]  out_sum1;
  logic [7:0]  out_count0, out_count1;
  logic        ovf0, ovf1, err0, err1;

  // Multiplier model controls
  logic        stub_hold;
  logic        cout_force;
  logic [7:0]  m_mcand = 8'd0;
  logic [7:0]  m_p     = 8'd0;
  logic [3:0]  m_mplr  = 4'd0;
  int          m_step  = 0;

  int n_tests = 0;
  int n_fail  = 0;

  dot_accum dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_load(mul_load0), .mul_a(mul_a0), .mul_b(mul_b0),
    .mul_valid(mul_valid), .mul_p(mul_p), .mul_cout(mul_cout),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(out_sum0), .out_count(out_count0),
    .ovf(ovf0), .err(err0)
  );

  dot_accum #(.G(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_load(mul_load1), .mul_a(mul_a1), .mul_b(mul_b1),
    .mul_valid(mul_valid), .mul_p(mul_p), .mul_cout(mul_cout),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(out_sum1), .out_count(out_count1),
    .ovf(ovf1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // N-cycle shift-add multiplier: one partial product per clock.
  always @(posedge clk) begin
    if (mul_load0) begin
      m_mcand <= {4'd0, mul_a0};
      m_mplr  <= mul_b0;
      m_p     <= 8'd0;
      m_step  <= N;
    end else if (m_step != 0) begin
      if (m_mplr[0]) m_p <= m_p + m_mcand;
      m_mcand <= m_mcand << 1;
      m_mplr  <= m_mplr >> 1;
      m_step  <= m_step - 1;
    end
  end

  assign mul_valid = (m_step == 0) && !stub_hold;
  assign mul_p     = m_p;
  assign mul_cout  = cout_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int k;
    k = 0;
    while (!in_ready0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", in_ready0, 1);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic busy_len(output int k);
    k = 0;
    while (!in_ready0 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_out(input string tag);
    int k;
    k = 0;
    while (!out_valid0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_out_valid"}, out_valid0, 1);
    chk({tag, "_out_valid_g1"}, out_valid1, 1);
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid0, 0);
    chk({tag, "_idle"}, in_ready0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    out_ready = 1'b0; stub_hold = 1'b0; cout_force = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_sum",   out_sum0,   0);
    chk("rst_out_count", out_count0, 0);
    chk("rst_ovf",       ovf0,       0);
    chk("rst_err",       err0,       0);
    chk("rst_mul_load",  mul_load0,  0);
    chk("rst_mul_a",     mul_a0,     0);
    chk("rst_mul_b",     mul_b0,     0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready",  in_ready0,  1);

    // ---------------- single element 3*5 ----------------
    send(4'd3, 4'd5, 1'b1);
    chk("issue_mul_load", mul_load0, 1);
    chk("issue_mul_a",    mul_a0,    3);
    chk("issue_mul_b",    mul_b0,    5);
    @(negedge clk);
    chk("wait_mul_load",  mul_load0, 0);
    chk("wait_mul_a",     mul_a0,    3);
    wait_out("single");
    chk("single_sum",   out_sum0,   15);
    chk("single_count", out_count0, 1);
    chk("single_ovf",   ovf0,       0);
    chk("single_sum_g1", out_sum1,  15);
    take_out("single");
    chk("single_cleared", out_sum0, 0);

    // ---------------- 225 + 225 + 1 with throughput ----------------
    send(4'd15, 4'd15, 1'b0);
    busy_len(k);
    chk("thru_busy_cycles", k, N + 2);
    send(4'd15, 4'd15, 1'b0);
    send(4'd1, 4'd1, 1'b1);
    wait_out("vec3");
    chk("vec3_sum",      out_sum0,   451);
    chk("vec3_count",    out_count0, 3);
    chk("vec3_ovf",      ovf0,       0);
    chk("vec3_sum_g1",   out_sum1,   451);
    chk("vec3_ovf_g1",   ovf1,       0);

    // ---------------- backpressure in OUT ----------------
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid0, 1);
      chk("bp_out_sum",   out_sum0,   451);
      chk("bp_out_count", out_count0, 3);
      chk("bp_in_ready",  in_ready0,  0);
    end
    take_out("vec3");

    // ---------------- 3 x 225 : G=1 overflows ----------------
    send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    wait_out("ovf");
    chk("ovf_sum_g4",   out_sum0,   675);
    chk("ovf_ovf_g4",   ovf0,       0);
    chk("ovf_count_g1", out_count1, 3);
    chk("ovf_ovf_g1",   ovf1,       1);
`ifdef DOT_ACCUM_SAT_EN
    chk("ovf_sum_g1_sat",  out_sum1, 511);
`else
    chk("ovf_sum_g1_wrap", out_sum1, 163);
`endif
    take_out("ovf");
    chk("ovf_cleared_g1", ovf1, 0);
    chk("sum_cleared_g1", out_sum1, 0);

    // ---------------- product carry sets ovf ----------------
    cout_force = 1'b1;
    send(4'd2, 4'd2, 1'b1);
    wait_out("cout");
    cout_force = 1'b0;
    chk("cout_ovf", ovf0, 1);
    take_out("cout");
    chk("cout_ovf_cleared", ovf0, 0);

    // ---------------- reset during WAIT, late mul_valid ----------------
    send(4'd5, 4'd5, 1'b0);
    busy_len(k);
    send(4'd7, 4'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_in_ready_rel", in_ready0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mrst_in_ready",  in_ready0,  1);
      chk("mrst_out_valid", out_valid0, 0);
    end
    chk("mrst_out_sum",   out_sum0,   0);
    chk("mrst_out_count", out_count0, 0);

    // ---------------- multiplier timeout ----------------
    send(4'd2, 4'd3, 1'b0);
    busy_len(k);
    chk("pre_tmo_sum", out_sum0, 6);
    stub_hold = 1'b1;
    send(4'd4, 4'd4, 1'b0);
    busy_len(k);
    stub_hold = 1'b0;
    chk("tmo_busy_cycles", k, TMO + 1);
    chk("tmo_err",       err0,       1);
    chk("tmo_in_ready",  in_ready0,  1);
    chk("tmo_sum_clr",   out_sum0,   0);
    chk("tmo_count_clr", out_count0, 0);

    // ---------------- err sticky until result taken ----------------
    send(4'd1, 4'd2, 1'b1);
    wait_out("post_tmo");
    chk("post_tmo_sum",   out_sum0,   2);
    chk("post_tmo_count", out_count0, 1);
    chk("post_tmo_err",   err0,       1);
    take_out("post_tmo");
    chk("err_cleared", err0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
